scoreboard_timer_ctrl: RTL and testbench

SCOREBOARD_TIMER_CTRL -- requirements
Module: scoreboard_timer_ctrl

---
 rtl/scoreboard_pkg.sv | 24 ++
 rtl/scoreboard_timer_ctrl_edge_pulse.sv | 18 +
 rtl/scoreboard_timer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_scoreboard_timer_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard game-clock controller.
package scoreboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_EXPIRED   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int SHOT_RELOAD = 24;

  // One point beats two beats three when presses land in the same cycle.
  function automatic logic [1:0] point_value(input logic i_one, input logic i_two,
                                             input logic i_three);
    if (i_one)        return 2'd1;
    else if (i_two)   return 2'd2;
    else if (i_three) return 2'd3;
    else              return 2'd0;
  endfunction

endpackage

// File: rtl/scoreboard_timer_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse in the cycle a button level first goes high.
module edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clock) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/scoreboard_timer_ctrl.sv
// Game clock, period counter and team scores for a scoreboard.
// Optional shot clock enabled by defining SCOREBOARD_SHOT_CLOCK_EN.
module scoreboard_timer_ctrl
  import scoreboard_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int PERIOD_MIN  = 12,
  parameter int NUM_PERIODS = 4,
  parameter int NUM_TEAMS   = 2,
  parameter int SCORE_W     = 8,
  parameter int MAX_SCORE   = 199
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           reset_clock,
  input  logic                           reset_points,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           next_period,
  input  logic [$clog2(NUM_TEAMS)-1:0]   team_sel,
  input  logic                           one_point,
  input  logic                           two_point,
  input  logic                           three_point,
`ifdef SCOREBOARD_SHOT_CLOCK_EN
  input  logic                           shot_reset,
  output logic [4:0]                     shot_sec,
  output logic                           shot_expired,
`endif
  output logic [6:0]                     minutes,
  output logic [5:0]                     seconds,
  output logic [3:0]                     period,
  output logic [NUM_TEAMS*SCORE_W-1:0]   scores,
  output logic [2:0]                     state,
  output logic                           buzzer
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(CLK_HZ - 1);
  localparam logic [6:0]         MIN_LOAD  = 7'(PERIOD_MIN);
  localparam logic [5:0]         SEC_LAST  = 6'(SEC_PER_MIN - 1);
  localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(MAX_SCORE);

  state_t             r_state, w_state_nxt;
  logic [PRE_W-1:0]   r_presc;
  logic [6:0]         r_min;
  logic [5:0]         r_sec;
  logic [3:0]         r_period;
  logic               r_buzzer;
  logic [SCORE_W-1:0] r_score [NUM_TEAMS];
  logic [SCORE_W-1:0] w_score_nxt [NUM_TEAMS];

  logic w_start_p, w_next_p, w_one_p, w_two_p, w_three_p;
  logic w_tick, w_expire, w_clk_reload, w_advance, w_apply;
  logic [1:0] w_pts;

  edge_pulse u_start (.clock(clock), .reset(reset), .i_level(start),       .o_pulse(w_start_p));
  edge_pulse u_next  (.clock(clock), .reset(reset), .i_level(next_period), .o_pulse(w_next_p));
  edge_pulse u_one   (.clock(clock), .reset(reset), .i_level(one_point),   .o_pulse(w_one_p));
  edge_pulse u_two   (.clock(clock), .reset(reset), .i_level(two_point),   .o_pulse(w_two_p));
  edge_pulse u_three (.clock(clock), .reset(reset), .i_level(three_point), .o_pulse(w_three_p));

  assign w_tick       = (r_state == ST_RUN) && (r_presc == PRE_MAX);
  assign w_expire     = w_tick && (r_min == 7'd0) && (r_sec == 6'd1);
  assign w_clk_reload = reset_clock && (r_state != ST_GAME_OVER);
  assign w_advance    = (r_state == ST_EXPIRED) && w_next_p && (r_period < 4'(NUM_PERIODS));

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_start_p) w_state_nxt = ST_RUN;
      ST_RUN:       if (w_expire) w_state_nxt = ST_EXPIRED;
                    else if (pause) w_state_nxt = ST_PAUSED;
      ST_PAUSED:    if (!pause) w_state_nxt = ST_RUN;
      ST_EXPIRED:   if (w_next_p) w_state_nxt = w_advance ? ST_IDLE : ST_GAME_OVER;
      ST_GAME_OVER: w_state_nxt = ST_GAME_OVER;
      default:      w_state_nxt = ST_IDLE;
    endcase
    if (w_clk_reload) w_state_nxt = ST_IDLE;
  end

  // Prescaler keeps its count through a pause so no fraction of a second is lost.
  always_ff @(posedge clock) begin
    if (reset || w_clk_reload) r_presc <= '0;
    else if (r_state == ST_RUN) r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_min    <= MIN_LOAD;
      r_sec    <= '0;
      r_period <= 4'd1;
      r_buzzer <= 1'b0;
    end else begin
      r_buzzer <= w_expire && !w_clk_reload;
      if (w_clk_reload) begin
        r_min <= MIN_LOAD;
        r_sec <= '0;
      end else if (w_advance) begin
        r_min    <= MIN_LOAD;
        r_sec    <= '0;
        r_period <= r_period + 4'd1;
      end else if (w_tick) begin
        if (r_sec != 6'd0) begin
          r_sec <= r_sec - 6'd1;
        end else begin
          r_min <= r_min - 7'd1;
          r_sec <= SEC_LAST;
        end
      end
    end
  end

  assign w_pts   = point_value(w_one_p, w_two_p, w_three_p);
  assign w_apply = (w_pts != 2'd0) && (int'(team_sel) < NUM_TEAMS) && !reset_points;

  always_comb begin
    logic [SCORE_W+1:0] v_sum;
    v_sum = '0;
    for (int k = 0; k < NUM_TEAMS; k++) begin
      v_sum = (SCORE_W+2)'(r_score[k]) + (SCORE_W+2)'(w_pts);
      w_score_nxt[k] = (v_sum > (SCORE_W+2)'(MAX_SCORE)) ? SCORE_CAP : v_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_TEAMS; k++) begin
      if (reset || reset_points) r_score[k] <= '0;
      else if (w_apply && (int'(team_sel) == k)) r_score[k] <= w_score_nxt[k];
    end
  end

  for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_pack
    assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
  end

`ifdef SCOREBOARD_SHOT_CLOCK_EN
  logic [4:0] r_shot;
  logic       r_shot_exp;

  // Any score that actually lands restarts the possession clock.
  always_ff @(posedge clock) begin
    if (reset || shot_reset || w_apply) begin
      r_shot     <= 5'(SHOT_RELOAD);
      r_shot_exp <= 1'b0;
    end else begin
      r_shot_exp <= w_tick && (r_shot == 5'd1);
      if (w_tick && (r_shot != 5'd0)) r_shot <= r_shot - 5'd1;
    end
  end

  assign shot_sec     = r_shot;
  assign shot_expired = r_shot_exp;
`endif

  assign minutes = r_min;
  assign seconds = r_sec;
  assign period  = r_period;
  assign state   = r_state;
  assign buzzer  = r_buzzer;

endmodule

// File: tb/tb_scoreboard_timer_ctrl.sv
// Bench for scoreboard_timer_ctrl: scoring vector table, directed clock sequences,
// and a random phase checked every cycle against a remaining-seconds reference model.
module tb_scoreboard_timer_ctrl;
  import scoreboard_pkg::*;

  localparam int CLK_HZ      = 10;
  localparam int PERIOD_MIN  = 1;
  localparam int NUM_PERIODS = 2;
  localparam int NUM_TEAMS   = 3;
  localparam int SCORE_W     = 8;
  localparam int MAX_SCORE   = 199;

  logic clock, reset, reset_clock, reset_points, start, pause, next_period;
  logic [1:0] team_sel;
  logic one_point, two_point, three_point, shot_reset;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic [3:0] period;
  logic [NUM_TEAMS*SCORE_W-1:0] scores;
  logic [2:0] state;
  logic buzzer;
`ifdef SCOREBOARD_SHOT_CLOCK_EN
  logic [4:0] shot_sec;
  logic shot_expired;
`endif

  scoreboard_timer_ctrl #(
    .CLK_HZ(CLK_HZ), .PERIOD_MIN(PERIOD_MIN), .NUM_PERIODS(NUM_PERIODS),
    .NUM_TEAMS(NUM_TEAMS), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clock(clock), .reset(reset), .reset_clock(reset_clock), .reset_points(reset_points),
    .start(start), .pause(pause), .next_period(next_period), .team_sel(team_sel),
    .one_point(one_point), .two_point(two_point), .three_point(three_point),
`ifdef SCOREBOARD_SHOT_CLOCK_EN
    .shot_reset(shot_reset), .shot_sec(shot_sec), .shot_expired(shot_expired),
`endif
    .minutes(minutes), .seconds(seconds), .period(period), .scores(scores),
    .state(state), .buzzer(buzzer)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int buz_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int score_of(input int k);
    return int'(scores[k*SCORE_W +: SCORE_W]);
  endfunction

  // ---------------- reference model ----------------
  state_t m_mode;
  int m_rem, m_sub, m_period, m_buz, m_shot, m_shot_exp;
  int m_score [NUM_TEAMS];
  logic h_start, h_next, h_one, h_two, h_three;

  task automatic model_step();
    bit ps, pn, p1, p2, p3, tick, clkrel, applied;
    int pts;
    ps = start && !h_start;
    pn = next_period && !h_next;
    p1 = one_point && !h_one;
    p2 = two_point && !h_two;
    p3 = three_point && !h_three;
    if (reset) begin
      {h_start, h_next, h_one, h_two, h_three} = '0;
      m_mode = ST_IDLE; m_rem = PERIOD_MIN * 60; m_sub = 0; m_period = 1;
      m_buz = 0; m_shot = 24; m_shot_exp = 0;
      for (int k = 0; k < NUM_TEAMS; k++) m_score[k] = 0;
      return;
    end
    {h_start, h_next, h_one, h_two, h_three} = {start, next_period, one_point, two_point, three_point};
    tick   = (m_mode == ST_RUN) && (m_sub == CLK_HZ - 1);
    clkrel = reset_clock && (m_mode != ST_GAME_OVER);
    m_buz = 0;
    m_shot_exp = 0;
    pts = p1 ? 1 : p2 ? 2 : p3 ? 3 : 0;
    applied = (pts != 0) && (int'(team_sel) < NUM_TEAMS) && !reset_points;
    if (shot_reset || applied) m_shot = 24;
    else if (tick && m_shot > 0) begin
      m_shot--;
      if (m_shot == 0) m_shot_exp = 1;
    end
    if (reset_points) begin
      for (int k = 0; k < NUM_TEAMS; k++) m_score[k] = 0;
    end else if (applied) begin
      m_score[team_sel] = (m_score[team_sel] + pts > MAX_SCORE) ? MAX_SCORE : m_score[team_sel] + pts;
    end
    if (clkrel) begin
      m_rem = PERIOD_MIN * 60; m_sub = 0; m_mode = ST_IDLE;
    end else begin
      case (m_mode)
        ST_IDLE:   if (ps) m_mode = ST_RUN;
        ST_RUN: begin
          if (tick) begin m_sub = 0; m_rem--; end
          else m_sub++;
          if (tick && m_rem == 0) begin m_mode = ST_EXPIRED; m_buz = 1; end
          else if (pause) m_mode = ST_PAUSED;
        end
        ST_PAUSED: if (!pause) m_mode = ST_RUN;
        ST_EXPIRED: if (pn) begin
          if (m_period < NUM_PERIODS) begin
            m_period++; m_rem = PERIOD_MIN * 60; m_mode = ST_IDLE;
          end else m_mode = ST_GAME_OVER;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    if (buzzer) buz_cnt++;
    check("m_state",   int'(state),   int'(m_mode));
    check("m_minutes", int'(minutes), m_rem / 60);
    check("m_seconds", int'(seconds), m_rem % 60);
    check("m_period",  int'(period),  m_period);
    check("m_buzzer",  int'(buzzer),  m_buz);
    for (int k = 0; k < NUM_TEAMS; k++) check("m_score", score_of(k), m_score[k]);
`ifdef SCOREBOARD_SHOT_CLOCK_EN
    check("m_shot_sec", int'(shot_sec), m_shot);
    check("m_shot_exp", int'(shot_expired), m_shot_exp);
`endif
  endtask

  task automatic clear_inputs();
    {reset_clock, reset_points, start, pause, next_period} = '0;
    {one_point, two_point, three_point, shot_reset} = '0;
    team_sel = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic press_next();
    next_period = 1'b1; cycle(); next_period = 1'b0; cycle();
  endtask

  // Runs until EXPIRED is seen; returns the cycle count or the bound on timeout.
  task automatic run_to_expiry(input int already, output int n);
    n = already;
    while (state != 3'(ST_EXPIRED) && n < 2000) begin
      cycle();
      n++;
    end
  endtask

  typedef struct {
    logic [1:0] team;
    logic one, two, three, rp;
    int e0, e1, e2;
  } score_vec_t;

  score_vec_t vecs [12];

  initial begin
    int n;
    int held_min, held_sec;

    vecs[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 0};
    vecs[2]  = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 3};
    vecs[3]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 3};
    vecs[4]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 4, 3};
    vecs[5]  = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4, 4};
    vecs[6]  = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2, 4, 4};
    vecs[7]  = '{2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2, 4, 4};
    vecs[8]  = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    vecs[9]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 0};
    vecs[10] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0};
    vecs[11] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2};

    clear_inputs();
    do_reset();
    check("rst_state",   int'(state),   int'(ST_IDLE));
    check("rst_minutes", int'(minutes), 1);
    check("rst_seconds", int'(seconds), 0);
    check("rst_period",  int'(period),  1);
    check("rst_buzzer",  int'(buzzer),  0);
    check("rst_score1",  score_of(1),   0);

    // Scoring vector table
    for (int i = 0; i < 12; i++) begin
      team_sel = vecs[i].team;
      {one_point, two_point, three_point, reset_points} =
        {vecs[i].one, vecs[i].two, vecs[i].three, vecs[i].rp};
      cycle();
      check("vec_s0", score_of(0), vecs[i].e0);
      check("vec_s1", score_of(1), vecs[i].e1);
      check("vec_s2", score_of(2), vecs[i].e2);
      clear_inputs();
      cycle();
    end

    // Held button scores once; then saturation at the cap
    team_sel = 2'd1;
    three_point = 1'b1;
    repeat (50) cycle();
    three_point = 1'b0;
    cycle();
    check("held_three", score_of(1), 3);
    reset_points = 1'b1; cycle(); reset_points = 1'b0;
    repeat (65) begin three_point = 1'b1; cycle(); three_point = 1'b0; cycle(); end
    two_point = 1'b1; cycle(); two_point = 1'b0; cycle();
    check("pre_sat", score_of(1), 197);
    three_point = 1'b1;
    repeat (50) cycle();
    three_point = 1'b0;
    cycle();
    check("sat_199", score_of(1), 199);
    one_point = 1'b1; cycle(); one_point = 1'b0; cycle();
    check("sat_hold", score_of(1), 199);
    one_point = 1'b1; three_point = 1'b1; reset_points = 1'b1;
    cycle();
    clear_inputs();
    check("rp_override", score_of(1), 0);
    cycle();

    // Full period expiry
    do_reset();
    buz_cnt = 0;
    press_start();
    check("start_run", int'(state), int'(ST_RUN));
    run_to_expiry(0, n);
    check("expire_cycles", n, 600);
    check("expire_min", int'(minutes), 0);
    check("expire_sec", int'(seconds), 0);
    check("expire_buz", int'(buzzer), 1);
    repeat (5) cycle();
    check("buz_pulses", buz_cnt, 1);
    check("stay_expired", int'(state), int'(ST_EXPIRED));

    press_next();
    check("np_period", int'(period), 2);
    check("np_state",  int'(state),  int'(ST_IDLE));
    check("np_min",    int'(minutes), 1);
    check("np_sec",    int'(seconds), 0);

    // Pause mid-second: frozen time, nothing lost overall
    press_start();
    n = 0;
    repeat (15) begin cycle(); n++; end
    pause = 1'b1;
    cycle(); n++;
    held_min = int'(minutes);
    held_sec = int'(seconds);
    repeat (36) begin cycle(); n++; end
    check("pause_state", int'(state), int'(ST_PAUSED));
    check("pause_min", int'(minutes), held_min);
    check("pause_sec", int'(seconds), held_sec);
    pause = 1'b0;
    run_to_expiry(n, n);
    check("pause_total", n, 637);

    // Last period ends the game; reset_clock cannot revive it
    press_next();
    check("game_over", int'(state), int'(ST_GAME_OVER));
    reset_clock = 1'b1; cycle(); reset_clock = 1'b0;
    press_start();
    check("go_sticky", int'(state), int'(ST_GAME_OVER));
    check("go_period", int'(period), 2);

    // reset_clock mid-run
    do_reset();
    press_start();
    repeat (25) cycle();
    reset_clock = 1'b1; cycle(); reset_clock = 1'b0;
    check("rc_state", int'(state), int'(ST_IDLE));
    check("rc_min", int'(minutes), 1);
    check("rc_sec", int'(seconds), 0);

`ifdef SCOREBOARD_SHOT_CLOCK_EN
    do_reset();
    check("shot_rst", int'(shot_sec), 24);
    press_start();
    repeat (240) cycle();
    check("shot_zero", int'(shot_sec), 0);
    check("shot_exp", int'(shot_expired), 1);
    cycle();
    check("shot_exp_pulse", int'(shot_expired), 0);
    team_sel = 2'd0; two_point = 1'b1; cycle(); two_point = 1'b0;
    check("shot_reload", int'(shot_sec), 24);
`endif

    // Random phase against the model
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      reset        = ($urandom_range(0, 1499) == 0);
      start        = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      next_period  = ($urandom_range(0, 7) == 0);
      reset_clock  = ($urandom_range(0, 299) == 0);
      reset_points = ($urandom_range(0, 99) == 0);
      team_sel     = 2'($urandom_range(0, 3));
      one_point    = ($urandom_range(0, 5) == 0);
      two_point    = ($urandom_range(0, 5) == 0);
      three_point  = ($urandom_range(0, 5) == 0);
      shot_reset   = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
